axi_line_master: RTL and testbench

AXI_LINE_MASTER -- requirements
Module: axi_line_master

---
 rtl/axi_pkg.sv | 21 ++
 rtl/axi_line_master_if.sv | 77 +++++++
 rtl/axi_line_master.sv | 132 +++++++++++++
 tb/tb_axi_line_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 types and encodings for line-granular masters.
// Provides addr/data/strb/len/size/burst/resp types plus size/burst/resp codes.
package axi_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;
  typedef logic [7:0]  len_t;
  typedef logic [2:0]  size_t;
  typedef logic [1:0]  burst_t;
  typedef logic [1:0]  resp_t;

  localparam size_t  SIZE_4_BYTE = 3'b010;
  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam resp_t  RESP_OKAY   = 2'b00;
  localparam resp_t  RESP_EXOKAY = 2'b01;
  localparam resp_t  RESP_SLVERR = 2'b10;
  localparam resp_t  RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_line_master_if.sv
// Line-request port plus AXI4 AR/R/AW/W/B channels of axi_line_master.
// master: DUT side (drives AXI requests, consumes responses); slave: peer side.
interface axi_line_master_if #(
  parameter int LINE_WORDS = 4
);
  import axi_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  addr_t                      req_addr;
  logic [LINE_WORDS*32-1:0]   req_wdata;
  logic                       rsp_valid;
  logic                       rsp_err;
  logic [LINE_WORDS*32-1:0]   rsp_rdata;

  addr_t  araddr;
  len_t   arlen;
  size_t  arsize;
  burst_t arburst;
  logic   arvalid;
  logic   arready;

  data_t  rdata;
  resp_t  rresp;
  logic   rlast;
  logic   rvalid;
  logic   rready;

  addr_t  awaddr;
  len_t   awlen;
  size_t  awsize;
  burst_t awburst;
  logic   awvalid;
  logic   awready;

  data_t  wdata;
  strb_t  wstrb;
  logic   wlast;
  logic   wvalid;
  logic   wready;

  resp_t  bresp;
  logic   bvalid;
  logic   bready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_line_master.sv
// Cache-line AXI4 master: one INCR burst of LINE_WORDS words per request.
// Ports: aclk, aresetn (sync, active-low), bus (axi_line_master_if.master).
module axi_line_master
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_line_master_if.master  bus
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int LB  = LINE_WORDS * 32;
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam logic [BW-1:0] LAST = BW'(LINE_WORDS - 1);
  localparam addr_t MASK = ~(addr_t'((64'd1 << OFF) - 64'd1));

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_e;

  state_e          state, state_nx;
  addr_t           addr;
  logic [LB-1:0]   wline;
  logic [LB-1:0]   rbuf;
  logic [LB-1:0]   rbuf_nx;
  logic [LB-1:0]   rline;
  logic [BW-1:0]   beat;
  logic            err;
  logic            last_beat;

  assign last_beat = (beat == LAST);

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.arvalid   = 1'b0;
    bus.rready    = 1'b0;
    bus.awvalid   = 1'b0;
    bus.wvalid    = 1'b0;
    bus.bready    = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid)
          state_nx = bus.req_write ? S_AW : S_AR;
      end
      S_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) state_nx = S_R;
      end
      S_R: begin
        bus.rready = 1'b1;
        if (bus.rvalid && last_beat) state_nx = S_DONE;
      end
      S_AW: begin
        bus.awvalid = 1'b1;
        if (bus.awready) state_nx = S_W;
      end
      S_W: begin
        bus.wvalid = 1'b1;
        if (bus.wready && last_beat) state_nx = S_B;
      end
      S_B: begin
        bus.bready = 1'b1;
        if (bus.bvalid) state_nx = S_DONE;
      end
      S_DONE: begin
        bus.rsp_valid = 1'b1;
        state_nx      = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Refill collects into rbuf; rline only updates when the line is whole,
  // so rsp_rdata keeps the previous line for the whole burst.
  always_comb begin
    rbuf_nx = rbuf;
    rbuf_nx[{beat, 5'd0} +: 32] = bus.rdata;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr  <= '0;
      beat  <= '0;
      err   <= 1'b0;
      rline <= '0;
    end else begin
      if (state == S_IDLE && bus.req_valid) begin
        addr  <= bus.req_addr & MASK;
        wline <= bus.req_wdata;
        beat  <= '0;
        err   <= 1'b0;
      end
      if (state == S_R && bus.rvalid) begin
        rbuf <= rbuf_nx;
        beat <= beat + BW'(1);
        if (bus.rresp != RESP_OKAY || bus.rlast != last_beat)
          err <= 1'b1;
        if (last_beat)
          rline <= rbuf_nx;
      end
      if (state == S_W && bus.wready)
        beat <= beat + BW'(1);
      if (state == S_B && bus.bvalid && bus.bresp != RESP_OKAY)
        err <= 1'b1;
    end
  end

  assign bus.araddr    = addr;
  assign bus.arlen     = len_t'(LINE_WORDS - 1);
  assign bus.arsize    = SIZE_4_BYTE;
  assign bus.arburst   = BURST_INCR;
  assign bus.awaddr    = addr;
  assign bus.awlen     = len_t'(LINE_WORDS - 1);
  assign bus.awsize    = SIZE_4_BYTE;
  assign bus.awburst   = BURST_INCR;
  assign bus.wdata     = wline[{beat, 5'd0} +: 32];
  assign bus.wstrb     = '1;
  assign bus.wlast     = (state == S_W) && last_beat;
  assign bus.rsp_err   = (state == S_DONE) && err;
  assign bus.rsp_rdata = rline;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed + randomized bench for axi_line_master (LINE_WORDS = 4).
// Reference model computes aligned address, expected line and error flag.
module tb_axi_line_master;
  import axi_pkg::*;

  localparam int LW = 4;
  localparam int LB = LW * 32;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  always #5 aclk = ~aclk;

  axi_line_master_if #(.LINE_WORDS(LW)) bus();

  axi_line_master #(.LINE_WORDS(LW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  data_t bd[LW];
  resp_t br[LW];
  logic  bl[LW];
  int    gap_max = 0;
  logic [LB-1:0] hold_line = '0;
  logic          hold_ok = 1'b1;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic addr_t align(input addr_t a);
    return a - (a % addr_t'(LW * 4));
  endfunction

  function automatic resp_t rnd_resp();
    if ($urandom_range(0, 5) == 0)
      return resp_t'($urandom_range(1, 3));
    return RESP_OKAY;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.arready   = 1'b0;
    bus.rdata     = '0;
    bus.rresp     = RESP_OKAY;
    bus.rlast     = 1'b0;
    bus.rvalid    = 1'b0;
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bresp     = RESP_OKAY;
    bus.bvalid    = 1'b0;
  endtask

  // Slave side of one refill; bd/br/bl hold the beats to return.
  task automatic read_txn(input addr_t a, input int ar_wait);
    logic [LB-1:0] line;
    logic e;
    int gaps;
    line = '0;
    e = 1'b0;
    for (int i = 0; i < LW; i++) begin
      line[i*32 +: 32] = bd[i];
      if (br[i] != RESP_OKAY) e = 1'b1;
      if (bl[i] != (i == LW - 1)) e = 1'b1;
    end
    chk("rd_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    @(negedge aclk);
    bus.req_valid = 1'b0;
    chk("arvalid", bus.arvalid, 1);
    chk("araddr", bus.araddr, align(a));
    chk("arlen", bus.arlen, LW - 1);
    chk("arsize", bus.arsize, 3'b010);
    chk("arburst", bus.arburst, 2'b01);
    chk("rd_busy", bus.req_ready, 0);
    for (int k = 0; k < ar_wait; k++) begin
      @(negedge aclk);
      chk("arvalid_hold", bus.arvalid, 1);
      chk("araddr_hold", bus.araddr, align(a));
      chk("arlen_hold", bus.arlen, LW - 1);
      chk("rd_busy_hold", bus.req_ready, 0);
    end
    bus.arready = 1'b1;
    @(negedge aclk);
    bus.arready = 1'b0;
    chk("arvalid_drop", bus.arvalid, 0);
    for (int i = 0; i < LW; i++) begin
      gaps = $urandom_range(0, gap_max);
      for (int g = 0; g < gaps; g++) begin
        bus.rvalid = 1'b0;
        bus.bvalid = 1'($urandom_range(0, 1));
        bus.bresp  = RESP_SLVERR;
        chk("stray_bready", bus.bready, 0);
        @(negedge aclk);
      end
      bus.bvalid = 1'b0;
      bus.bresp  = RESP_OKAY;
      bus.rvalid = 1'b1;
      bus.rdata  = bd[i];
      bus.rresp  = br[i];
      bus.rlast  = bl[i];
      chk("rready", bus.rready, 1);
      chk("rd_no_rsp", bus.rsp_valid, 0);
      if (hold_ok && i == LW - 1)
        chk("rd_hold", bus.rsp_rdata, hold_line);
      @(negedge aclk);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = RESP_OKAY;
    chk("rd_rsp_valid", bus.rsp_valid, 1);
    chk("rd_rsp_err", bus.rsp_err, e);
    chk("rd_rsp_rdata", bus.rsp_rdata, line);
    hold_line = line;
    hold_ok = 1'b1;
    @(negedge aclk);
    chk("rd_rsp_pulse", bus.rsp_valid, 0);
  endtask

  // mode 0: wready toggles 1,0,1,0..; mode 1: random wready.
  task automatic write_txn(input addr_t a, input logic [LB-1:0] line,
                           input int aw_wait, input int mode,
                           input resp_t bres, input int b_wait);
    int i;
    int c;
    chk("wr_req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = line;
    @(negedge aclk);
    bus.req_valid = 1'b0;
    chk("awvalid", bus.awvalid, 1);
    chk("awaddr", bus.awaddr, align(a));
    chk("awlen", bus.awlen, LW - 1);
    chk("awsize", bus.awsize, 3'b010);
    chk("awburst", bus.awburst, 2'b01);
    chk("wr_no_ar", bus.arvalid, 0);
    for (int k = 0; k < aw_wait; k++) begin
      @(negedge aclk);
      chk("awvalid_hold", bus.awvalid, 1);
      chk("awaddr_hold", bus.awaddr, align(a));
    end
    bus.awready = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0;
    chk("awvalid_drop", bus.awvalid, 0);
    i = 0;
    c = 0;
    while (i < LW && c < 8 * LW) begin
      chk("wvalid", bus.wvalid, 1);
      chk("wdata", bus.wdata, line[i*32 +: 32]);
      chk("wlast", bus.wlast, (i == LW - 1));
      chk("wstrb", bus.wstrb, 4'hF);
      if (mode == 0)      bus.wready = (c % 2 == 0);
      else if (c >= 4*LW) bus.wready = 1'b1;
      else                bus.wready = 1'($urandom_range(0, 1));
      @(negedge aclk);
      if (bus.wready) i++;
      c++;
    end
    if (i < LW) chk("w_timeout", i, LW);
    bus.wready = 1'b0;
    chk("wvalid_drop", bus.wvalid, 0);
    for (int k = 0; k < b_wait; k++) begin
      bus.rvalid = 1'b1;
      bus.rresp  = RESP_SLVERR;
      bus.rdata  = $urandom;
      chk("stray_rready", bus.rready, 0);
      chk("wr_no_rsp", bus.rsp_valid, 0);
      @(negedge aclk);
    end
    bus.rvalid = 1'b0;
    bus.rresp  = RESP_OKAY;
    bus.bvalid = 1'b1;
    bus.bresp  = bres;
    chk("bready", bus.bready, 1);
    @(negedge aclk);
    bus.bvalid = 1'b0;
    bus.bresp  = RESP_OKAY;
    chk("wr_rsp_valid", bus.rsp_valid, 1);
    chk("wr_rsp_err", bus.rsp_err, (bres != RESP_OKAY));
    hold_ok = 1'b0;
    @(negedge aclk);
    chk("wr_rsp_pulse", bus.rsp_valid, 0);
  endtask

  task automatic ok_beats();
    for (int i = 0; i < LW; i++) begin
      bd[i] = $urandom;
      br[i] = RESP_OKAY;
      bl[i] = (i == LW - 1);
    end
  endtask

  initial begin
    logic [LB-1:0] wl;
    idle_inputs();
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Basic refill from an unaligned address.
    for (int i = 0; i < LW; i++) begin
      bd[i] = 32'hA0 + i;
      br[i] = RESP_OKAY;
      bl[i] = (i == LW - 1);
    end
    read_txn(32'h0000_1234, 0);

    // Address channel stalled five cycles.
    ok_beats();
    read_txn(32'h0000_5678, 5);

    // Writeback with wready toggling.
    wl = {32'h44, 32'h33, 32'h22, 32'h11};
    write_txn(32'h0000_2004, wl, 0, 0, RESP_OKAY, 0);

    // SLVERR on beat 2, then a clean refill clears the flag.
    ok_beats();
    br[2] = RESP_SLVERR;
    read_txn(32'h0000_3000, 1);
    ok_beats();
    read_txn(32'h0000_3040, 0);

    // Early rlast on beat 1, none on beat 3.
    ok_beats();
    bl[1] = 1'b1;
    bl[3] = 1'b0;
    read_txn(32'h0000_4010, 0);

    // Randomized mix.
    gap_max = 2;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < LW; i++) begin
          bd[i] = $urandom;
          br[i] = rnd_resp();
          bl[i] = (i == LW - 1);
          if ($urandom_range(0, 7) == 0) bl[i] = ~bl[i];
        end
        read_txn($urandom, $urandom_range(0, 3));
      end else begin
        for (int i = 0; i < LW; i++) wl[i*32 +: 32] = $urandom;
        write_txn($urandom, wl, $urandom_range(0, 3), 1, rnd_resp(),
                  $urandom_range(0, 2));
      end
    end
    gap_max = 0;

    // Reset while the third write beat is on the bus.
    wl = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_7000;
    bus.req_wdata = wl;
    @(negedge aclk);
    bus.req_valid = 1'b0;
    bus.awready = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0;
    bus.wready = 1'b1;
    repeat (2) @(negedge aclk);
    chk("rst_w_beat2", bus.wdata, 32'hC2);
    bus.wready = 1'b0;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("rst_w_wvalid", bus.wvalid, 0);
    chk("rst_w_req_ready", bus.req_ready, 1);
    chk("rst_w_rsp_valid", bus.rsp_valid, 0);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_rsp_valid", bus.rsp_valid, 0);
    chk("post_rst_rdata", bus.rsp_rdata, 0);
    hold_line = '0;
    hold_ok = 1'b1;

    // Recovery after reset.
    ok_beats();
    read_txn(32'h0000_8888, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
